// File: rtl/tc_pl_cap_mch_ctl.sv
// rtl/tc_pl_cap_mch_ctl.sv - multi-channel capture trigger/complete/timeout control
// Per-channel IDLE->TRIG->WAIT sequencer with sticky W1C status and a shared completion count.
module tc_pl_cap_mch_ctl #(
    parameter int N_CH    = 2,
    parameter int TRIG_W  = 4,
    parameter int TMO_W   = 24,
    parameter int TMO_CYC = 12500000
) (
    input  logic              clk125,
    input  logic              rst,
    input  logic [N_CH-1:0]   cap_cing,
    input  logic [N_CH-1:0]   cap_cmpt,
    output logic [N_CH-1:0]   cap_trig,
    input  logic [31:0]       gp_ctl,
    input  logic              gp_ctl_wr,
    output logic [4*N_CH-1:0] gp_sts,
    output logic [15:0]       done_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TRIG = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int              TC_W      = (TRIG_W > 1) ? $clog2(TRIG_W) : 1;
    localparam logic [TC_W-1:0] TRIG_LAST = TC_W'(TRIG_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam bit              TMO_EN    = (TMO_CYC != 0);

    logic [1:0]       state    [N_CH];
    logic [TC_W-1:0]  trig_cnt [N_CH];
    logic [TMO_W-1:0] tmo_cnt  [N_CH];
    logic [N_CH-1:0]  cmpt_st;
    logic [N_CH-1:0]  tmo_st;
    logic [N_CH-1:0]  cing_q;

    logic [N_CH-1:0]  arm;
    logic [N_CH-1:0]  clr;
    logic [N_CH-1:0]  abt;
    logic [N_CH-1:0]  acc;
    logic [N_CH-1:0]  tmo_hit;
    logic [3:0]       n_acc;
    logic [16:0]      done_sum;
    logic             unused_gp;

    // Mask bits above N_CH are simply never looked at.
    assign unused_gp = ^gp_ctl;

    always_comb begin
        arm     = '0;
        clr     = '0;
        abt     = '0;
        acc     = '0;
        tmo_hit = '0;
        n_acc   = '0;
        for (int i = 0; i < N_CH; i++) begin
            arm[i] = gp_ctl_wr & gp_ctl[i];
            clr[i] = gp_ctl_wr & gp_ctl[8+i];
            abt[i] = gp_ctl_wr & gp_ctl[16+i];
            // Abort beats a same-cycle completion: nothing is flagged or counted.
            acc[i] = cap_cmpt[i] && (state[i] != ST_IDLE) && !abt[i];
            tmo_hit[i] = TMO_EN && (state[i] == ST_WAIT) && (tmo_cnt[i] == TMO_LAST)
                         && !cap_cmpt[i] && !abt[i];
            n_acc = n_acc + {3'b000, acc[i]};
        end
        done_sum = {1'b0, done_cnt} + {13'd0, n_acc};
    end

    always_ff @(posedge clk125) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i]    <= ST_IDLE;
                trig_cnt[i] <= '0;
                tmo_cnt[i]  <= '0;
            end
            cap_trig <= '0;
            cmpt_st  <= '0;
            tmo_st   <= '0;
            cing_q   <= '0;
            done_cnt <= '0;
        end else begin
            cing_q <= cap_cing;
            if (gp_ctl_wr && gp_ctl[31])
                done_cnt <= '0;
            else if (done_sum[16])
                done_cnt <= 16'hFFFF;
            else
                done_cnt <= done_sum[15:0];

            for (int i = 0; i < N_CH; i++) begin
                cmpt_st[i] <= acc[i] | (cmpt_st[i] & ~clr[i]);
                tmo_st[i]  <= tmo_hit[i] | (tmo_st[i] & ~clr[i]);
                case (state[i])
                    ST_IDLE: begin
                        if (arm[i] && !abt[i]) begin
                            state[i]    <= ST_TRIG;
                            cap_trig[i] <= 1'b1;
                            trig_cnt[i] <= '0;
                        end
                    end
                    ST_TRIG: begin
                        if (abt[i] || acc[i]) begin
                            state[i]    <= ST_IDLE;
                            cap_trig[i] <= 1'b0;
                        end else if (trig_cnt[i] == TRIG_LAST) begin
                            state[i]    <= ST_WAIT;
                            cap_trig[i] <= 1'b0;
                            tmo_cnt[i]  <= '0;
                        end else begin
                            trig_cnt[i] <= trig_cnt[i] + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (abt[i] || acc[i] || tmo_hit[i])
                            state[i] <= ST_IDLE;
                        else
                            tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
                    end
                    default: begin
                        state[i]    <= ST_IDLE;
                        cap_trig[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        gp_sts = '0;
        for (int i = 0; i < N_CH; i++)
            gp_sts[4*i +: 4] = {(state[i] != ST_IDLE), cing_q[i], tmo_st[i], cmpt_st[i]};
    end

endmodule

// File: tb/tb_tc_pl_cap_mch_ctl.sv
// tb/tb_tc_pl_cap_mch_ctl.sv - directed self-checking bench for tc_pl_cap_mch_ctl
module tb_tc_pl_cap_mch_ctl;

    logic        clk125 = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cap_cing = '0;
    logic [1:0]  cap_cmpt = '0;
    logic [1:0]  cap_trig;
    logic [31:0] gp_ctl = '0;
    logic        gp_ctl_wr = 1'b0;
    logic [7:0]  gp_sts;
    logic [15:0] done_cnt;

    int n_vec = 0;
    int n_err = 0;

    tc_pl_cap_mch_ctl #(
        .N_CH(2), .TRIG_W(4), .TMO_W(24), .TMO_CYC(50)
    ) dut (
        .clk125(clk125), .rst(rst), .cap_cing(cap_cing), .cap_cmpt(cap_cmpt),
        .cap_trig(cap_trig), .gp_ctl(gp_ctl), .gp_ctl_wr(gp_ctl_wr),
        .gp_sts(gp_sts), .done_cnt(done_cnt)
    );

    always #4 clk125 = ~clk125;

    task automatic tick();
        @(posedge clk125);
        #1;
    endtask

    task automatic wr_ctl(input logic [31:0] v);
        gp_ctl = v;
        gp_ctl_wr = 1'b1;
        tick();
        gp_ctl_wr = 1'b0;
        gp_ctl = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_vec++; if (cap_trig !== 2'b00) begin n_err++; $display("FAIL reset_trig got %b want 00", cap_trig); end
        n_vec++; if (gp_sts !== 8'h00) begin n_err++; $display("FAIL reset_sts got %h want 00", gp_sts); end
        n_vec++; if (done_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_cnt got %h want 0000", done_cnt); end
    endtask

    task automatic test_basic();
        tick();
        wr_ctl(32'h0000_0001);
        for (int k = 0; k < 6; k++) begin
            n_vec++; if (cap_trig[0] !== (k < 4)) begin n_err++; $display("FAIL basic_trig k=%0d got %b want %b", k, cap_trig[0], (k < 4)); end
            if (k == 0) begin
                n_vec++; if (gp_sts[3] !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", gp_sts[3]); end
            end
            tick();
        end
        cap_cmpt = 2'b01;
        tick();
        cap_cmpt = 2'b00;
        n_vec++; if (gp_sts[3:0] !== 4'b0001) begin n_err++; $display("FAIL basic_cmpt_sts got %b want 0001", gp_sts[3:0]); end
        n_vec++; if (done_cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt got %0d want 1", done_cnt); end
        wr_ctl(32'h0000_0100);
        n_vec++; if (gp_sts[0] !== 1'b0) begin n_err++; $display("FAIL basic_w1c got %b want 0", gp_sts[0]); end
    endtask

    task automatic test_timeout();
        wr_ctl(32'h0000_0002);
        repeat (53) tick();
        n_vec++; if (gp_sts[7:4] !== 4'b1000) begin n_err++; $display("FAIL tmo_early got %b want 1000", gp_sts[7:4]); end
        tick();
        n_vec++; if (gp_sts[7:4] !== 4'b0010) begin n_err++; $display("FAIL tmo_set got %b want 0010", gp_sts[7:4]); end
        n_vec++; if (done_cnt !== 16'd1) begin n_err++; $display("FAIL tmo_cnt got %0d want 1", done_cnt); end
        repeat (5) tick();
        n_vec++; if (cap_trig[1] !== 1'b0) begin n_err++; $display("FAIL tmo_trig got %b want 0", cap_trig[1]); end
    endtask

    task automatic test_dual();
        wr_ctl(32'h0000_0203);
        repeat (6) tick();
        cap_cmpt = 2'b11;
        tick();
        cap_cmpt = 2'b00;
        n_vec++; if (done_cnt !== 16'd3) begin n_err++; $display("FAIL dual_cnt got %0d want 3", done_cnt); end
        n_vec++; if (gp_sts !== 8'h11) begin n_err++; $display("FAIL dual_sts got %h want 11", gp_sts); end
        wr_ctl(32'h0000_0300);
        n_vec++; if (gp_sts !== 8'h00) begin n_err++; $display("FAIL dual_clr got %h want 00", gp_sts); end
    endtask

    task automatic test_abort();
        wr_ctl(32'h0000_0001);
        tick();
        wr_ctl(32'h0000_0001);
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (cap_trig[0] !== (k < 2)) begin n_err++; $display("FAIL abort_rearm k=%0d got %b want %b", k, cap_trig[0], (k < 2)); end
            tick();
        end
        n_vec++; if (gp_sts[3] !== 1'b1) begin n_err++; $display("FAIL abort_wait got %b want 1", gp_sts[3]); end
        wr_ctl(32'h0001_0000);
        n_vec++; if (gp_sts[3:0] !== 4'b0000) begin n_err++; $display("FAIL abort_sts got %b want 0000", gp_sts[3:0]); end
        cap_cmpt = 2'b01;
        tick();
        cap_cmpt = 2'b00;
        n_vec++; if (gp_sts[0] !== 1'b0) begin n_err++; $display("FAIL idle_cmpt_sts got %b want 0", gp_sts[0]); end
        n_vec++; if (done_cnt !== 16'd3) begin n_err++; $display("FAIL idle_cmpt_cnt got %0d want 3", done_cnt); end
    endtask

    task automatic test_sat();
        wr_ctl(32'h0000_0001);
        repeat (6) tick();
        gp_ctl = 32'h0000_0100;
        gp_ctl_wr = 1'b1;
        cap_cmpt = 2'b01;
        tick();
        gp_ctl_wr = 1'b0;
        gp_ctl = '0;
        cap_cmpt = 2'b00;
        n_vec++; if (gp_sts[0] !== 1'b1) begin n_err++; $display("FAIL set_over_clr got %b want 1", gp_sts[0]); end
        n_vec++; if (done_cnt !== 16'd4) begin n_err++; $display("FAIL set_over_clr_cnt got %0d want 4", done_cnt); end
        wr_ctl(32'h8000_0000);
        n_vec++; if (done_cnt !== 16'd0) begin n_err++; $display("FAIL cnt_clr got %0d want 0", done_cnt); end
        for (int n = 0; n < 32767; n++) begin
            wr_ctl(32'h0000_0003);
            cap_cmpt = 2'b11;
            tick();
            cap_cmpt = 2'b00;
        end
        n_vec++; if (done_cnt !== 16'hFFFE) begin n_err++; $display("FAIL cnt_fill got %h want fffe", done_cnt); end
        wr_ctl(32'h0000_0003);
        cap_cmpt = 2'b11;
        tick();
        cap_cmpt = 2'b00;
        n_vec++; if (done_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_sat2 got %h want ffff", done_cnt); end
        wr_ctl(32'h0000_0001);
        cap_cmpt = 2'b01;
        tick();
        cap_cmpt = 2'b00;
        n_vec++; if (done_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_sat1 got %h want ffff", done_cnt); end
        wr_ctl(32'h0000_0001);
        gp_ctl = 32'h8000_0000;
        gp_ctl_wr = 1'b1;
        cap_cmpt = 2'b01;
        tick();
        gp_ctl_wr = 1'b0;
        gp_ctl = '0;
        cap_cmpt = 2'b00;
        n_vec++; if (done_cnt !== 16'd0) begin n_err++; $display("FAIL clr_over_inc got %h want 0000", done_cnt); end
    endtask

    task automatic test_mid_reset();
        cap_cing = 2'b01;
        wr_ctl(32'h0000_0001);
        n_vec++; if (gp_sts[3:0] !== 4'b1101) begin n_err++; $display("FAIL pre_rst_sts got %b want 1101", gp_sts[3:0]); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (cap_trig !== 2'b00) begin n_err++; $display("FAIL mid_rst_trig got %b want 00", cap_trig); end
        n_vec++; if (gp_sts !== 8'h00) begin n_err++; $display("FAIL mid_rst_sts got %h want 00", gp_sts); end
        n_vec++; if (done_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got %h want 0000", done_cnt); end
        tick();
        n_vec++; if (gp_sts !== 8'h04) begin n_err++; $display("FAIL post_rst_sts got %h want 04", gp_sts); end
        cap_cing = 2'b00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_dual();
        test_abort();
        test_sat();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tc_pl_cap_mch_ctl.md
Name: tc_pl_cap_mch_ctl

Overview:
Multi-channel successor to the single-channel capture GP control block. The PS drives it through a GP control word and write strobe. Per channel it:
- issues a stretched capture-trigger pulse,
- waits for capture completion, with a timeout,
- keeps sticky complete/timeout flags that the PS clears by writing 1 to them.
A shared saturating count of completed captures is also exported. It sits between the PS GP registers and N_CH capture engines in the PL.

Parameters:
N_CH, 2, number of capture channels (1..8)
TRIG_W, 4, cap_trig pulse width in clk125 cycles (>=1)
TMO_W, 24, width of the per-channel timeout counter
TMO_CYC, 12500000, timeout in cycles (100 ms at 125 MHz); 0 disables timeout

Ports:
clk125  in  1  system clock, 125 MHz
rst  in  1  synchronous reset, active-high
cap_cing  in  N_CH  per-channel "capturing" level from the capture engines
cap_cmpt  in  N_CH  per-channel capture-complete pulse, 1 cycle
cap_trig  out  N_CH  per-channel capture trigger, high for TRIG_W cycles
gp_ctl  in  32  PS control word, sampled only on gp_ctl_wr
gp_ctl_wr  in  1  PS write strobe, 1 cycle
gp_sts  out  4*N_CH  per-channel status nibble
done_cnt  out  16  count of completed captures, saturating

Behaviour:
- Clock and reset:
  - One clock, clk125. rst is synchronous and active-high.
  - On rst: all channels go to IDLE; cap_trig=0; sticky flags=0; timeout counters=0; done_cnt=0; gp_sts=0.
  - rst asserted mid-operation aborts immediately, with no flags set.
- gp_ctl fields:
  - [7:0] arm mask
  - [15:8] W1C clear mask
  - [23:16] abort mask
  - [31] clear done_cnt
  - Bits for channels >= N_CH are ignored.
- Per-channel FSM: IDLE -> TRIG -> WAIT -> IDLE.
  - IDLE: arm bit on gp_ctl_wr -> TRIG. Arm in any other state is ignored.
  - TRIG: cap_trig=1 for exactly TRIG_W cycles, starting the cycle after gp_ctl_wr (1-cycle latency), then -> WAIT.
  - WAIT: timeout counter increments every cycle.
    - cap_cmpt -> set cmpt sticky and go to IDLE.
    - Counter reaching TMO_CYC-1 without cap_cmpt -> set tmo sticky and go to IDLE.
    - TMO_CYC=0 means WAIT without timeout.
  - cap_cmpt during TRIG: accepted. Sets cmpt sticky, ends the pulse next cycle, goes to IDLE.
  - cap_cmpt in IDLE: ignored. No flag, no count.
  - Abort bit in TRIG or WAIT: go to IDLE next cycle, cap_trig drops, no sticky set. Abort in IDLE has no effect.
  - Abort and arm for the same channel in one write: abort wins, channel stays IDLE.
- Sticky flags (cmpt, tmo):
  - Cleared by a clear-mask bit on gp_ctl_wr.
  - A set event in the same cycle as a clear wins (flag=1).
  - Clear and arm in the same write: the clear applies and the arm is taken normally.
- gp_sts nibble for channel i, bits [4i+3:4i]:
  - [0] cmpt sticky
  - [1] tmo sticky
  - [2] cap_cing[i], registered one cycle
  - [3] busy (state != IDLE)
- done_cnt:
  - Each cycle, adds the number of channels that accepted a cap_cmpt that cycle. Simultaneous completions are all counted.
  - Saturates at 16'hFFFF; no wrap.
  - gp_ctl[31] on gp_ctl_wr sets done_cnt=0, and that clear wins over increments in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
1. Reset, then gp_ctl=32'h0000_0001 with wr at cycle 10 -> cap_trig[0]=1 on cycles 11-14 (TRIG_W=4); gp_sts[3]=1 from cycle 11; cap_cmpt[0] pulse at cycle 20 -> gp_sts[0]=1 at cycle 21, busy=0, done_cnt=1; write 32'h0000_0100 -> gp_sts[0]=0.
2. TMO_CYC=50: arm ch1 and send no cap_cmpt -> tmo sticky (gp_sts[5]) set exactly 50 cycles after WAIT entry; done_cnt unchanged; cap_trig[1] stays 0 afterwards.
3. Arm ch0 and ch1 together; both cap_cmpt pulse in the same cycle -> done_cnt increments by 2; both cmpt stickies set.
4. Arm ch0, then write abort 32'h0001_0000 during WAIT -> busy=0 next cycle, no sticky set; re-arm during TRIG is ignored (no second pulse).
5. Same-cycle clear (wr 32'h0000_0100) and cap_cmpt[0] -> gp_sts[0] remains 1; preload done_cnt to 16'hFFFF, complete another capture -> stays 16'hFFFF; write 32'h8000_0000 -> 0.
6. Assert rst for 1 cycle during ch0 TRIG -> cap_trig=0, gp_sts=0 and done_cnt=0 the next cycle.
